forward_pass_sequencer: RTL
===========================

Name: forward_pass_sequencer

Overview:
Controller that drives forward_pass_top in place of a bench.
- Accepts a load stream of (control, value) words and forwards each to the accelerator's control/in_bus pins.
- Issues the run command (control = 0) and waits for done, with a watchdog.
- Captures the 10 dense_softmax outputs, which stream out one per cycle from done, and returns the argmax class and score over a valid/ready result port.

Parameters:
BUS_WIDTH, 32, width of data buses (signed two's complement)
NUM_CLASSES, 10, number of output scores captured after done
IDLE_CTL, 4'd15, no-op control code driven when nothing is being loaded
TIMEOUT_CYCLES, 1000000, max cycles in RUN before declaring timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  load word valid
s_ready  out  1  load word accepted when s_valid & s_ready
s_ctl  in  4  control code for load word
s_val  in  BUS_WIDTH  signed value for load word
s_last  in  1  marks final load word of an inference
fp_control  out  4  to forward_pass_top control
fp_in_bus  out  BUS_WIDTH  to forward_pass_top in_bus
fp_done  in  1  from forward_pass_top done
fp_out_bus  in  BUS_WIDTH  from forward_pass_top out_bus
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_class  out  4  argmax index, 4'hF on timeout
res_score  out  BUS_WIDTH  max score, 0 on timeout
res_timeout  out  1  result is a watchdog timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; fp_control = IDLE_CTL; fp_in_bus, res_class, res_score = 0; res_valid, res_timeout, busy = 0; s_ready = 1 one cycle after reset release and whenever in IDLE/LOAD.
- States: IDLE, LOAD, RUN, COLLECT, RESULT.
- IDLE:
  - s_ready = 1; fp_control = IDLE_CTL.
  - Accepted word is forwarded.
  - Next state: LOAD, or RUN if s_last.
- LOAD:
  - s_ready = 1.
  - Each accepted word: registered fp_control <= s_ctl and fp_in_bus <= s_val (1-cycle latency, one word per cycle).
  - Cycle with no handshake: fp_control <= IDLE_CTL, fp_in_bus holds.
  - Accepted word with s_last: next state RUN.
  - s_ctl == 0 in a load word is illegal. The word is consumed and forwarded as IDLE_CTL; the run command is never issued from the stream.
- RUN:
  - s_ready = 0; fp_control held 0, first driven on the cycle after the last word is on the pins.
  - Watchdog counter cleared on entry, increments each cycle.
  - fp_done sampled high: capture fp_out_bus as score[0], go to COLLECT.
  - Counter reaches TIMEOUT_CYCLES-1 without done: go to RESULT with res_timeout = 1, res_class = 4'hF, res_score = 0.
  - fp_done high in IDLE/LOAD is ignored.
- COLLECT:
  - Capture fp_out_bus on each of the next NUM_CLASSES-1 cycles as score[1..9], regardless of fp_done level.
  - fp_control stays 0.
  - Argmax is computed incrementally as each score arrives (signed compare, strict greater-than, so a tie keeps the lowest index).
  - After score[9]: go to RESULT.
- RESULT:
  - res_valid = 1; res_class/res_score/res_timeout stable until handshake.
  - fp_control = IDLE_CTL.
  - On handshake: res_valid <= 0 and go to IDLE; s_ready is 1 on the following cycle.
- Counters: collect index is a 4-bit counter 0..NUM_CLASSES-1. Watchdog width is clog2(TIMEOUT_CYCLES); it saturates and does not wrap.
- Reset asserted mid-operation (any state): immediate return to reset values. A partially loaded inference is discarded, and no result is produced for it.

Test Plan:
- Load 4 words (ctl 1,1,2,3; val 5,-7,64,128; last on 4th), accelerator model asserts done 20 cycles into RUN with scores [3,-2,90,15,0,7,-100,89,1,2] -> fp_control seq 1,1,2,3,0..; res_class = 2, res_score = 90, res_timeout = 0.
- Same load with s_valid low for 3 cycles between words 2 and 3 -> fp_control shows IDLE_CTL x3 in gap, values unchanged otherwise; same result.
- Scores [-5,-1,-1,-9,-3,-2,-8,-4,-6,-7] -> res_class = 1, res_score = -1 (signed, tie keeps lowest index).
- TIMEOUT_CYCLES = 50, done never asserted -> res_valid after exactly 50 RUN cycles, res_timeout = 1, res_class = 15, res_score = 0.
- res_ready held low 10 cycles after res_valid -> outputs stable, s_ready = 0. Then res_ready = 1 -> res_valid drops next edge, s_ready = 1 the cycle after.
- rst_n pulsed low during COLLECT at index 4 -> all outputs at reset values immediately; next full inference returns the correct argmax.

Source files
------------

// File: rtl/forward_pass_sequencer.sv
// forward_pass_sequencer: drives a forward_pass_top accelerator from a load
// stream. It forwards (control, value) words, issues the run command, waits
// for done under a watchdog, captures the streamed class scores, and returns
// the argmax class and score on a valid/ready result port.
module forward_pass_sequencer #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned NUM_CLASSES    = 10,
  parameter logic [3:0]  IDLE_CTL       = 4'd15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // load stream
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3:0]           s_ctl,
  input  logic [BUS_WIDTH-1:0] s_val,
  input  logic                 s_last,
  // accelerator pins
  output logic [3:0]           fp_control,
  output logic [BUS_WIDTH-1:0] fp_in_bus,
  input  logic                 fp_done,
  input  logic [BUS_WIDTH-1:0] fp_out_bus,
  // result port
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_class,
  output logic [BUS_WIDTH-1:0] res_score,
  output logic                 res_timeout,
  output logic                 busy
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);
  localparam logic [3:0]       RUN_CTL  = 4'd0;
  localparam logic [3:0]       TO_CLASS = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COLLECT = 3'd3,
    ST_RESULT  = 3'd4
  } state_e;

  state_e                       state_q;
  logic                         s_ready_q;
  logic [3:0]                   fp_control_q;
  logic [BUS_WIDTH-1:0]         fp_in_bus_q;
  logic                         res_valid_q;
  logic [3:0]                   res_class_q;
  logic [BUS_WIDTH-1:0]         res_score_q;
  logic                         res_timeout_q;
  logic                         busy_q;
  logic [WD_W-1:0]              wd_q;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             best_idx_q;
  logic signed [BUS_WIDTH-1:0]  best_score_q;

  logic                         s_fire;
  logic                         res_fire;
  logic [3:0]                   fwd_ctl;
  logic                         score_gt;

  // Handshakes, illegal-run-command filter and running argmax compare
  always_comb begin
    s_fire   = s_valid & s_ready_q;
    res_fire = res_valid_q & res_ready;
    fwd_ctl  = (s_ctl == RUN_CTL) ? IDLE_CTL : s_ctl;
    score_gt = $signed(fp_out_bus) > best_score_q;
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      s_ready_q     <= 1'b0;
      fp_control_q  <= IDLE_CTL;
      fp_in_bus_q   <= '0;
      res_valid_q   <= 1'b0;
      res_class_q   <= '0;
      res_score_q   <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      wd_q          <= '0;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (s_fire) begin
            fp_control_q <= fwd_ctl;
            fp_in_bus_q  <= s_val;
            busy_q       <= 1'b1;
            if (s_last) begin
              // last word stays on the pins for the first RUN cycle
              state_q   <= ST_RUN;
              s_ready_q <= 1'b0;
              wd_q      <= '0;
            end else begin
              state_q   <= ST_LOAD;
              s_ready_q <= 1'b1;
            end
          end else begin
            fp_control_q <= IDLE_CTL;
            s_ready_q    <= 1'b1;
          end
        end

        ST_RUN: begin
          fp_control_q <= RUN_CTL;
          if (fp_done) begin
            best_score_q <= $signed(fp_out_bus);
            best_idx_q   <= '0;
            idx_q        <= IDX_W'(1);
            state_q      <= ST_COLLECT;
          end else if (wd_q >= WD_LAST) begin
            state_q       <= ST_RESULT;
            fp_control_q  <= IDLE_CTL;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            res_class_q   <= TO_CLASS;
            res_score_q   <= '0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end

        ST_COLLECT: begin
          fp_control_q <= RUN_CTL;
          if (score_gt) begin
            best_score_q <= $signed(fp_out_bus);
            best_idx_q   <= idx_q;
          end
          if (idx_q >= IDX_LAST) begin
            // fold the final score directly into the published result
            state_q       <= ST_RESULT;
            fp_control_q  <= IDLE_CTL;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b0;
            res_class_q   <= score_gt ? idx_q : best_idx_q;
            res_score_q   <= score_gt ? fp_out_bus : best_score_q;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        ST_RESULT: begin
          fp_control_q <= IDLE_CTL;
          if (res_fire) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            s_ready_q   <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          s_ready_q    <= 1'b0;
          fp_control_q <= IDLE_CTL;
          res_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Output ports driven straight from registers
  assign s_ready     = s_ready_q;
  assign fp_control  = fp_control_q;
  assign fp_in_bus   = fp_in_bus_q;
  assign res_valid   = res_valid_q;
  assign res_class   = res_class_q;
  assign res_score   = res_score_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;

endmodule
